// File: rtl/bm_pkg.sv
// Shared constants, FSM state encoding and small helpers for the branch metric controller.
package bm_pkg;

    localparam int MAX_STATE_NUM    = 256;
    localparam int RADIX            = 4;
    localparam int SLICED_INPUT_NUM = 6;
    localparam int FRAME_W          = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRECALC = 3'd1,
        ST_FLUSH   = 3'd2,
        ST_STREAM  = 3'd3,
        ST_DONE    = 3'd4
    } bm_state_e;

    // Any state other than IDLE keeps the metric unit enabled and the block busy.
    function automatic logic bm_is_active(input bm_state_e st);
        return (st != ST_IDLE);
    endfunction

endpackage

// File: rtl/bm_sweep_cnt.sv
// State/input sweep counter: walks state 0..last_state with the input index
// innermost (0..RADIX-1) and holds on the final pair so the state count
// can never wrap past its width.
module bm_sweep_cnt #(
    parameter int STATE_W = 8,
    parameter int RADIX   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear_i,
    input  logic                       enable_i,
    input  logic [STATE_W-1:0]         last_state_i,
    output logic [STATE_W-1:0]         state_o,
    output logic [$clog2(RADIX)-1:0]   input_o,
    output logic                       done_o
);

    localparam int IN_W = $clog2(RADIX);
    localparam logic [IN_W-1:0] IN_LAST = IN_W'(RADIX - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [IN_W-1:0]    input_q, input_d;

    assign state_o = state_q;
    assign input_o = input_q;
    assign done_o  = (state_q == last_state_i) && (input_q == IN_LAST);

    // Next-count logic: clear wins, then advance unless already on the final pair.
    always_comb begin
        state_d = state_q;
        input_d = input_q;
        if (clear_i) begin
            state_d = {STATE_W{1'b0}};
            input_d = {IN_W{1'b0}};
        end else if (enable_i && !done_o) begin
            if (input_q == IN_LAST) begin
                input_d = {IN_W{1'b0}};
                state_d = state_q + STATE_W'(1'b1);
            end else begin
                input_d = input_q + IN_W'(1'b1);
            end
        end else begin
            state_d = state_q;
            input_d = input_q;
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= {STATE_W{1'b0}};
            input_q <= {IN_W{1'b0}};
        end else begin
            state_q <= state_d;
            input_q <= input_d;
        end
    end

endmodule

// File: rtl/branch_metric_ctrl.sv
// Branch metric controller: precalculates the metric table by sweeping every
// (state, input) pair through the metric unit, then streams received symbols
// into the metric lookup until a frame of the latched length has been taken.
module branch_metric_ctrl #(
    parameter int MAX_STATE_NUM    = bm_pkg::MAX_STATE_NUM,
    parameter int RADIX            = bm_pkg::RADIX,
    parameter int SLICED_INPUT_NUM = bm_pkg::SLICED_INPUT_NUM
) (
    input  logic                                                         clk,
    input  logic                                                         rst,
    input  logic                                                         i_start,
    input  logic                                                         i_abort,
    input  logic [$clog2(MAX_STATE_NUM)-1:0]                             i_state_num_m1,
    input  logic [bm_pkg::FRAME_W-1:0]                                   i_frame_len,
    input  logic [SLICED_INPUT_NUM-1:0]                                  i_code,
    input  logic                                                         i_rx_valid,
    input  logic [SLICED_INPUT_NUM-1:0]                                  i_rx,
    output logic [$clog2(RADIX)+$clog2(MAX_STATE_NUM)+SLICED_INPUT_NUM-1:0] o_mux,
    output logic                                                         o_en_bm,
    output logic                                                         o_rx_ready,
    output logic [SLICED_INPUT_NUM-1:0]                                  o_rx,
    output logic                                                         o_rx_valid,
    output logic                                                         o_busy,
    output logic                                                         o_pre_done,
    output logic                                                         o_frame_done
);

    import bm_pkg::*;

    localparam int STATE_W = $clog2(MAX_STATE_NUM);
    localparam int IN_W    = $clog2(RADIX);
    localparam int MUX_W   = IN_W + STATE_W + SLICED_INPUT_NUM;

    bm_state_e                   state_q, state_d;
    logic [STATE_W-1:0]          s_num_q;
    logic [FRAME_W-1:0]          frame_len_q;
    logic [FRAME_W-1:0]          sym_cnt_q, sym_cnt_d;
    logic [MUX_W-1:0]            mux_hold_q;
    logic [SLICED_INPUT_NUM-1:0] rx_q;
    logic                        rx_valid_q;
    logic                        busy_q, en_bm_q, rx_ready_q, pre_done_q, frame_done_q;

    logic                        sw_clear_s, sw_en_s, sw_done_s;
    logic [STATE_W-1:0]          sw_state_s;
    logic [IN_W-1:0]             sw_input_s;
    logic [MUX_W-1:0]            mux_s;
    logic                        accept_s, last_sym_s, start_s;

    // Counter sits cleared in IDLE so a new frame (or one after an abort) starts at pair (0,0).
    assign sw_clear_s = (state_q == ST_IDLE);
    assign sw_en_s    = (state_q == ST_PRECALC);

    bm_sweep_cnt #(
        .STATE_W (STATE_W),
        .RADIX   (RADIX)
    ) u_sweep (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (sw_clear_s),
        .enable_i     (sw_en_s),
        .last_state_i (s_num_q),
        .state_o      (sw_state_s),
        .input_o      (sw_input_s),
        .done_o       (sw_done_s)
    );

    assign mux_s      = {sw_input_s, sw_state_s, i_code};
    assign start_s    = (state_q == ST_IDLE) && i_start && !i_abort;
    assign accept_s   = i_rx_valid && rx_ready_q && !i_abort;
    assign last_sym_s = ((sym_cnt_q + FRAME_W'(1'b1)) == frame_len_q);

    // Metric unit address: live (and combinational in i_code) while sweeping,
    // otherwise the last swept pair so any further table writes are harmless.
    always_comb begin
        o_mux = mux_hold_q;
        if (state_q == ST_PRECALC) begin
            o_mux = mux_s;
        end else begin
            o_mux = mux_hold_q;
        end
    end

    // Next-state and symbol-count logic; abort overrides every transition.
    always_comb begin
        state_d   = state_q;
        sym_cnt_d = sym_cnt_q;
        if (state_q == ST_IDLE) begin
            sym_cnt_d = {FRAME_W{1'b0}};
        end else if (accept_s) begin
            sym_cnt_d = sym_cnt_q + FRAME_W'(1'b1);
        end else begin
            sym_cnt_d = sym_cnt_q;
        end

        if (i_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_d = ST_PRECALC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PRECALC: begin
                    if (sw_done_s) begin
                        state_d = ST_FLUSH;
                    end else begin
                        state_d = ST_PRECALC;
                    end
                end
                ST_FLUSH: begin
                    if (frame_len_q == {FRAME_W{1'b0}}) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (accept_s && last_sym_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, latched frame parameters, symbol path and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            s_num_q      <= {STATE_W{1'b0}};
            frame_len_q  <= {FRAME_W{1'b0}};
            sym_cnt_q    <= {FRAME_W{1'b0}};
            mux_hold_q   <= {MUX_W{1'b0}};
            rx_q         <= {SLICED_INPUT_NUM{1'b0}};
            rx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            en_bm_q      <= 1'b0;
            rx_ready_q   <= 1'b0;
            pre_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sym_cnt_q <= sym_cnt_d;
            if (start_s) begin
                s_num_q     <= i_state_num_m1;
                frame_len_q <= i_frame_len;
            end
            if (state_q == ST_PRECALC) begin
                mux_hold_q <= mux_s;
            end
            if (accept_s) begin
                rx_q <= i_rx;
            end
            rx_valid_q   <= accept_s;
            busy_q       <= bm_is_active(state_d);
            en_bm_q      <= bm_is_active(state_d);
            rx_ready_q   <= (state_d == ST_STREAM);
            pre_done_q   <= (state_d == ST_FLUSH);
            frame_done_q <= (state_d == ST_DONE);
        end
    end

    assign o_en_bm      = en_bm_q;
    assign o_rx_ready   = rx_ready_q;
    assign o_rx         = rx_q;
    assign o_rx_valid   = rx_valid_q;
    assign o_busy       = busy_q;
    assign o_pre_done   = pre_done_q;
    assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_branch_metric_ctrl.sv
// Directed self-checking bench for branch_metric_ctrl.
module tb_branch_metric_ctrl;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic        i_abort;
    logic [7:0]  i_state_num_m1;
    logic [15:0] i_frame_len;
    logic [5:0]  i_code;
    logic        i_rx_valid;
    logic [5:0]  i_rx;
    logic [15:0] o_mux;
    logic        o_en_bm;
    logic        o_rx_ready;
    logic [5:0]  o_rx;
    logic        o_rx_valid;
    logic        o_busy;
    logic        o_pre_done;
    logic        o_frame_done;

    int          n_checks;
    int          n_errors;
    int          cyc;
    logic [5:0]  last_code;
    logic [5:0]  last_rx;

    branch_metric_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .i_start        (i_start),
        .i_abort        (i_abort),
        .i_state_num_m1 (i_state_num_m1),
        .i_frame_len    (i_frame_len),
        .i_code         (i_code),
        .i_rx_valid     (i_rx_valid),
        .i_rx           (i_rx),
        .o_mux          (o_mux),
        .o_en_bm        (o_en_bm),
        .o_rx_ready     (o_rx_ready),
        .o_rx           (o_rx),
        .o_rx_valid     (o_rx_valid),
        .o_busy         (o_busy),
        .o_pre_done     (o_pre_done),
        .o_frame_done   (o_frame_done)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop if the sequence ever stalls.
    initial begin
        #500000;
        $display("FAIL watchdog: obs=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; new i_code is applied after the edge and given time to settle.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        i_code = 6'(cyc * 5 + 1);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},  32'(o_busy),       32'd0);
        check({tag, "_en"},    32'(o_en_bm),      32'd0);
        check({tag, "_rdy"},   32'(o_rx_ready),   32'd0);
        check({tag, "_pre"},   32'(o_pre_done),   32'd0);
        check({tag, "_fdone"}, 32'(o_frame_done), 32'd0);
    endtask

    task automatic start_frame(input logic [7:0] s, input logic [15:0] fl);
        i_state_num_m1 = s;
        i_frame_len    = fl;
        i_start        = 1'b1;
        tick();
        i_start        = 1'b0;
    endtask

    // Called on the first PRECALC cycle; returns on the FLUSH cycle.
    task automatic sweep(input int s);
        logic [9:0] kv;
        for (int k = 0; k < (s + 1) * 4; k++) begin
            kv = 10'(k);
            check("pc_mux", 32'(o_mux), 32'({kv[1:0], kv[9:2], i_code}));
            check("pc_en",  32'(o_en_bm), 32'd1);
            check("pc_pre", 32'(o_pre_done), 32'd0);
            check("pc_rdy", 32'(o_rx_ready), 32'd0);
            last_code = i_code;
            tick();
        end
        check("flush_pre",  32'(o_pre_done), 32'd1);
        check("flush_busy", 32'(o_busy), 32'd1);
        check("flush_mux",  32'(o_mux), 32'({2'b11, 8'(s), last_code}));
    endtask

    initial begin
        logic [19:0] pat;
        int          sent;
        int          n;
        logic        acc;

        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        rst      = 1'b1;
        i_start  = 1'b0;
        i_abort  = 1'b0;
        i_state_num_m1 = 8'd0;
        i_frame_len    = 16'd0;
        i_code         = 6'd0;
        i_rx_valid     = 1'b0;
        i_rx           = 6'd0;
        last_rx        = 6'd0;

        // Reset state.
        tick();
        tick();
        check_idle("rst");
        check("rst_mux", 32'(o_mux), 32'd0);
        check("rst_rx",  32'(o_rx), 32'd0);
        check("rst_rxv", 32'(o_rx_valid), 32'd0);
        rst = 1'b0;
        tick();

        // S=3, frame_len=5 with gaps in i_rx_valid.
        start_frame(8'd3, 16'd5);
        sweep(3);
        tick();
        check("st_rdy", 32'(o_rx_ready), 32'd1);
        check("st_mux", 32'(o_mux), 32'({2'b11, 8'd3, last_code}));
        pat  = 20'b0000_0000_0001_0100_1101;
        sent = 0;
        for (int i = 0; i < 20 && sent < 5; i++) begin
            check("st_rdy_loop", 32'(o_rx_ready), 32'd1);
            i_rx_valid = pat[i];
            i_rx       = 6'(i * 7 + 3);
            acc        = pat[i];
            tick();
            if (acc) begin
                sent++;
                last_rx = i_rx;
            end
            check("st_rxv", 32'(o_rx_valid), 32'(acc));
            check("st_rx",  32'(o_rx), 32'(last_rx));
            check("st_fdone", 32'(o_frame_done), 32'(sent == 5));
        end
        check("st_count", 32'(sent), 32'd5);
        check("done_rdy",  32'(o_rx_ready), 32'd0);
        check("done_busy", 32'(o_busy), 32'd1);
        i_rx_valid = 1'b1;
        i_rx       = 6'h3F;
        tick();
        i_rx_valid = 1'b0;
        check("post_rxv", 32'(o_rx_valid), 32'd0);
        check("post_rx",  32'(o_rx), 32'(last_rx));
        check_idle("post");

        // S=0, frame_len=0: FLUSH then DONE, never ready.
        i_rx_valid = 1'b1;
        start_frame(8'd0, 16'd0);
        sweep(0);
        check("z_rdy0", 32'(o_rx_ready), 32'd0);
        tick();
        check("z_fdone", 32'(o_frame_done), 32'd1);
        check("z_pre",   32'(o_pre_done), 32'd0);
        check("z_rdy1",  32'(o_rx_ready), 32'd0);
        check("z_rxv",   32'(o_rx_valid), 32'd0);
        tick();
        i_rx_valid = 1'b0;
        check_idle("z_end");

        // Abort has priority over start in IDLE.
        i_abort = 1'b1;
        i_start = 1'b1;
        tick();
        i_abort = 1'b0;
        i_start = 1'b0;
        check_idle("ab_prio");

        // Abort on PRECALC cycle 7, then restart from pair (0,0).
        start_frame(8'd3, 16'd5);
        for (int k = 0; k < 6; k++) tick();
        check("ab_pc_mux", 32'(o_mux[15:6]), 32'h201);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check_idle("ab_pc");
        tick();
        check_idle("ab_pc2");
        start_frame(8'd3, 16'd5);
        check("ab_restart", 32'(o_mux[15:6]), 32'h000);
        sweep(3);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check_idle("ab_flush");

        // Reset mid-STREAM after 3 of 10; start during STREAM is ignored.
        start_frame(8'd1, 16'd10);
        sweep(1);
        tick();
        i_rx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_rx = 6'(i + 40);
            tick();
        end
        check("ms_rx", 32'(o_rx), 32'd42);
        i_rx_valid = 1'b0;
        i_start    = 1'b1;
        i_state_num_m1 = 8'd7;
        tick();
        i_start = 1'b0;
        check("ms_rdy",  32'(o_rx_ready), 32'd1);
        check("ms_pre",  32'(o_pre_done), 32'd0);
        check("ms_mux",  32'(o_mux[15:6]), 32'h301);
        rst = 1'b1;
        tick();
        check_idle("ms_rst");
        check("ms_rst_mux", 32'(o_mux), 32'd0);
        check("ms_rst_rx",  32'(o_rx), 32'd0);
        check("ms_rst_rxv", 32'(o_rx_valid), 32'd0);
        rst = 1'b0;
        tick();

        // S=255: 1024 PRECALC cycles, FLUSH 1025 cycles after the start edge.
        start_frame(8'hFF, 16'd1);
        n = 1;
        while (!o_pre_done && n < 1100) begin
            check("big_mux", 32'(o_mux), 32'({2'(n - 1), 8'((n - 1) >> 2), i_code}));
            last_code = i_code;
            tick();
            n++;
        end
        check("big_lat", 32'(n), 32'd1025);
        tick();
        check("big_rdy", 32'(o_rx_ready), 32'd1);
        check("big_mux_hold", 32'(o_mux), 32'({2'b11, 8'hFF, last_code}));
        i_rx_valid = 1'b1;
        i_rx       = 6'h15;
        tick();
        i_rx_valid = 1'b0;
        check("big_rxv",   32'(o_rx_valid), 32'd1);
        check("big_fdone", 32'(o_frame_done), 32'd1);
        check("big_mux_done", 32'(o_mux), 32'({2'b11, 8'hFF, last_code}));
        tick();
        check_idle("big_end");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
